// File: rtl/rca_pkg.sv
// -----------------------------------------------------------------------------
// rca_pkg
// Shared definitions for the sequential ripple-carry add/subtract controller.
//   SLICE_W     : width of the shared adder slice (bits processed per clock)
//   state_t     : controller state encoding (IDLE / RUN / DONE)
//   num_slices  : number of slices needed to cover an operand of a given width
// -----------------------------------------------------------------------------
package rca_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_slices(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/rca.sv
// -----------------------------------------------------------------------------
// rca
// Combinational 4-bit ripple-carry adder slice.
//   a, b  : slice operands
//   cin   : carry into bit 0
//   sum   : slice sum
//   cout  : carry out of bit 3
//   cmsb  : carry into bit 3 (lets the caller form signed overflow on the
//           most significant slice)
// -----------------------------------------------------------------------------
module rca
  import rca_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               cmsb
);

  // Carries are kept as separate scalars so the ripple chain is explicit.
  logic c1;
  logic c2;
  logic c3;
  logic c4;

  assign sum[0] = a[0] ^ b[0] ^ cin;
  assign c1     = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));

  assign sum[1] = a[1] ^ b[1] ^ c1;
  assign c2     = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));

  assign sum[2] = a[2] ^ b[2] ^ c2;
  assign c3     = (a[2] & b[2]) | (c2 & (a[2] ^ b[2]));

  assign sum[3] = a[3] ^ b[3] ^ c3;
  assign c4     = (a[3] & b[3]) | (c3 & (a[3] ^ b[3]));

  assign cout = c4;
  assign cmsb = c3;

endmodule

// File: rtl/rca_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rca_seq_ctrl
// Sequential add/subtract unit: one shared 4-bit ripple-carry slice is reused
// once per clock, least significant slice first, to form a WIDTH-bit result.
//
// Ports
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   in_valid/ready  : request handshake; op_a, op_b, sub sampled on accept
//   op_a, op_b      : operands; sub = 0 -> A+B, sub = 1 -> A-B
//   out_valid/ready : result handshake
//   result          : WIDTH-bit sum/difference
//   cout            : final carry (1 = no borrow on subtract)
//   ovf             : signed overflow
//   busy            : high whenever the controller is not IDLE
//   dbg_state       : current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, out_valid only in DONE; once
// out_valid is high, result/cout/ovf hold until the edge where out_ready=1,
// after which the controller returns to IDLE.
//
// Timing: the accepting edge enters RUN. The next WIDTH/4 edges each process
// one slice. One further edge latches cout/ovf from the finished carry chain
// and enters DONE, so out_valid rises WIDTH/4+1 edges after the accept.
// -----------------------------------------------------------------------------
module rca_seq_ctrl
  import rca_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output state_t           dbg_state
);

  localparam int NSLICE = num_slices(WIDTH);
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t             state_q;
  state_t             state_d;
  logic [IDX_W-1:0]   idx_q;
  // Set after the last slice has been written; the following RUN edge is the
  // wrap-up cycle that latches cout/ovf and moves to DONE.
  logic               fin_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               sub_q;
  logic               carry_q;
  logic               cmsb_q;
  logic [WIDTH-1:0]   result_q;
  logic               cout_q;
  logic               ovf_q;

  // ---------------------------------------------------------------------------
  // Slice selection and the shared adder
  // ---------------------------------------------------------------------------
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b_raw;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic               slice_cmsb;

  always_comb begin
    slice_a     = a_q[int'(idx_q) * SLICE_W +: SLICE_W];
    slice_b_raw = b_q[int'(idx_q) * SLICE_W +: SLICE_W];
    // Subtraction is A + ~B + 1; the +1 comes from the carry register, which
    // is loaded with sub on accept.
    slice_b     = sub_q ? ~slice_b_raw : slice_b_raw;
  end

  rca u_rca (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout),
    .cmsb (slice_cmsb)
  );

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (fin_q)     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      fin_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      cmsb_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= op_a;
            b_q     <= op_b;
            sub_q   <= sub;
            idx_q   <= '0;
            fin_q   <= 1'b0;
            carry_q <= sub;
          end
        end
        RUN: begin
          if (!fin_q) begin
            result_q[int'(idx_q) * SLICE_W +: SLICE_W] <= slice_sum;
            carry_q <= slice_cout;
            cmsb_q  <= slice_cmsb;
            if (idx_q == LAST_IDX) begin
              idx_q <= '0;
              fin_q <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            // carry_q now holds the carry out of the MSB, cmsb_q the carry
            // into the MSB of the top slice.
            cout_q <= carry_q;
            ovf_q  <= cmsb_q ^ carry_q;
            fin_q  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rca_seq_ctrl
// Directed bench for rca_seq_ctrl (WIDTH=16). Expected {result,cout,ovf}
// values come from a behavioural model and travel through exp_q from the
// point a request is accepted to the point the controller presents it.
// -----------------------------------------------------------------------------
module tb_rca_seq_ctrl;
  import rca_pkg::*;

  localparam int WIDTH = 16;
  localparam int EW    = WIDTH + 2;
  localparam int LAT   = WIDTH / 4 + 1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             busy;
  state_t           dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rca_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // {result, cout, ovf} for A+B or A-B (A + ~B + 1).
  function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic s);
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   t;
    logic             o;
    bb = s ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, s};
    o  = (a[WIDTH-1] == bb[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
    return {t[WIDTH-1:0], t[WIDTH], o};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Presents a request and returns once it has been accepted (#1 after the
  // accepting edge). Operands are then scrambled to show they are ignored.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic s, input logic keep_valid, output int acc_cyc);
    int n;
    @(negedge clk);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_ready", 64'(in_ready), 64'd1);
    exp_q.push_back(model(a, b, s));
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!keep_valid) in_valid = 1'b0;
    op_a = WIDTH'($urandom);
    op_b = WIDTH'($urandom);
    sub  = 1'($urandom_range(0, 1));
    chk("busy_after_accept", 64'(busy), 64'd1);
  endtask

  // Waits (bounded) for out_valid, checks latency and the result, applies
  // `hold` cycles of backpressure, then releases the result.
  task automatic collect(input string tag, input int hold);
    int n;
    logic [EW-1:0] e;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(LAT));
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_nonempty"}, 64'd0, 64'd1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    chk({tag, "_result"}, 64'({result, cout, ovf}), 64'(e));
    chk({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_stable"}, 64'({out_valid, in_ready, result, cout, ovf}),
          64'({1'b1, 1'b0, e}));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_back_to_idle"}, 64'({dbg_state, out_valid}), 64'({IDLE, 1'b0}));
    chk({tag, "_idle_keeps"}, 64'({result, cout, ovf}), 64'(e));
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int acc;
    int prev_acc;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic rs;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; sub = 1'b0;
    #1;
    chk("reset_outputs", 64'({in_ready, out_valid, busy, result, cout, ovf}),
        64'({1'b1, 1'b0, 1'b0, {WIDTH{1'b0}}, 1'b0, 1'b0}));
    chk("reset_state", 64'(dbg_state), 64'(IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic add, carry ripple through all slices, subtract with borrow,
    // signed overflow.
    send(16'h1234, 16'h4321, 1'b0, 1'b0, acc);
    collect("add_1234_4321", 0);
    chk("add_1234_4321_exact", 64'(result), 64'h5555);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, acc);
    collect("add_ffff_0001", 0);
    chk("add_ffff_0001_exact", 64'({result, cout, ovf}), 64'({16'h0000, 1'b1, 1'b0}));
    send(16'h0000, 16'h0001, 1'b1, 1'b0, acc);
    collect("sub_0000_0001", 0);
    chk("sub_0000_0001_exact", 64'({result, cout}), 64'({16'hFFFF, 1'b0}));
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, acc);
    collect("add_7fff_0001", 0);
    chk("add_7fff_0001_exact", 64'({result, ovf}), 64'({16'h8000, 1'b1}));

    // Backpressure for 10 cycles.
    send(16'h8000, 16'h0001, 1'b1, 1'b0, acc);
    collect("sub_bp", 10);

    // Random operands.
    for (int i = 0; i < 6; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rs = 1'($urandom_range(0, 1));
      send(ra, rb, rs, 1'b0, acc);
      collect("random", $urandom_range(0, 3));
    end

    // Reset in the middle of RUN (slice 2); the aborted request yields nothing.
    @(negedge clk);
    op_a = 16'h1111; op_b = 16'h2222; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("pre_reset_run", 64'(dbg_state), 64'(RUN));
    rst = 1'b1;
    #1;
    chk("midrun_reset_outputs", 64'({in_ready, out_valid, busy, result, cout, ovf}),
        64'({1'b1, 1'b0, 1'b0, {WIDTH{1'b0}}, 1'b0, 1'b0}));
    chk("midrun_reset_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    op_a = 16'hABCD; op_b = 16'h1234; sub = 1'b1; in_valid = 1'b1;
    exp_q.push_back(model(16'hABCD, 16'h1234, 1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("accept_after_reset", 64'(busy), 64'd1);
    collect("after_reset", 0);

    // Back-to-back with in_valid held high.
    send(16'h0F0F, 16'h00F1, 1'b0, 1'b1, prev_acc);
    collect("b2b", 0);
    for (int i = 0; i < 4; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rs = 1'(i & 1);
      send(ra, rb, rs, 1'b1, acc);
      chk("b2b_gap_ge6", 64'((acc - prev_acc) >= 6), 64'd1);
      prev_acc = acc;
      collect("b2b", 0);
    end
    in_valid = 1'b0;

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rca_seq_ctrl.md
RCA_SEQ_CTRL -- requirements
Module: rca_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values are multiples of 4, from 8 to 64.
REQ-002 SHALL have ports: clk  in  1  single clock, all state changes on its rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: in_valid  in  1  request present; in_ready  out  1  controller can accept.
REQ-005 SHALL have ports: op_a, op_b  in  WIDTH  operands; sub  in  1  0 = A+B, 1 = A-B.
REQ-006 SHALL have ports: out_valid  out  1  result present; out_ready  in  1  consumer takes result.
REQ-007 SHALL have ports: result  out  WIDTH  sum/difference; cout  out  1  final carry (1 = no borrow on sub); ovf  out  1  signed overflow.
REQ-008 SHALL have ports: busy  out  1  high in every state except IDLE.

Function
REQ-009 SHALL compute all arithmetic through one shared 4-bit ripple-carry adder slice, processing one 4-bit slice per clock, LSB slice first.
REQ-010 SHALL implement states IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-011 SHALL, in IDLE with in_valid=1, capture op_a, op_b and sub, clear the slice index, load the carry register with sub, and go to RUN.
REQ-012 SHALL, when sub=1, present ~op_b slices to the adder (two's complement via carry-in = 1).
REQ-013 SHALL, in RUN cycle k (k = 0..WIDTH/4-1), write the adder sum to result[4k+3:4k] and the adder carry-out to the carry register.
REQ-014 SHALL, after slice WIDTH/4-1, go to DONE, with cout = the last carry and ovf = carry into the MSB XOR carry out of the MSB.
REQ-015 SHALL have fixed latency: out_valid rises exactly WIDTH/4+1 rising edges after the accepting edge (5 for WIDTH=16).
REQ-016 SHALL hold result, cout and ovf stable in DONE while out_ready=0 (backpressure, unbounded).
REQ-017 SHALL, in DONE with out_ready=1, return to IDLE on the next edge; a same-cycle in_valid is not accepted, because in_ready=0 in DONE.
REQ-018 SHALL ignore op_a, op_b, sub and in_valid changes while in RUN or DONE.
REQ-019 SHALL keep result, cout and ovf unchanged in IDLE (last result remains readable).

Reset
REQ-020 SHALL, on rst=1 at any time, including mid-RUN, immediately force state=IDLE, slice index=0, carry=0, result=0, cout=0, ovf=0, out_valid=0, busy=0 and in_ready=1.
REQ-021 SHALL discard any partially computed operation on reset, with no output produced for it.
REQ-022 SHALL accept a request on the first rising edge after rst deasserts.

Structure
REQ-023 SHALL place the state enumeration (IDLE/RUN/DONE) and SLICE_W=4 in a shared package, rca_pkg.
REQ-024 SHALL instantiate the existing rca module once as its only sub-module; no other adder logic is permitted.
REQ-025 SHALL size the slice index as clog2(WIDTH/4) bits; the index wraps to 0 on leaving RUN.

Verification
REQ-026 SHALL cover: 0x1234 + 0x4321, sub=0 -> result 0x5555, cout 0, ovf 0, out_valid on 5th edge after accept.
REQ-027 SHALL cover: 0xFFFF + 0x0001 -> result 0x0000, cout 1, ovf 0 (full carry ripple across all slices).
REQ-028 SHALL cover: 0x0000 - 0x0001 -> result 0xFFFF, cout 0; and 0x7FFF + 0x0001 -> result 0x8000, ovf 1.
REQ-029 SHALL cover: out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready 0; then out_ready=1 -> IDLE next edge.
REQ-030 SHALL cover: rst pulsed in RUN slice 2 -> all outputs at reset values immediately; the next request computes correctly.
REQ-031 SHALL cover: back-to-back requests, with in_valid held 1 continuously -> one accept per 6+ cycles, each result correct, no request lost.
